// File: rtl/i2c_cmd_pkg.sv
// Shared command encodings, FSM states and step indices for the SCCB/I2C
// register sequencer and the bit-shift engine.
package i2c_cmd_pkg;

  localparam int CMD_W = 6;

  // Cmd is a one-hot OR of these; the engine decodes each bit independently
  localparam logic [CMD_W-1:0] CMD_WR   = 6'h01;
  localparam logic [CMD_W-1:0] CMD_STA  = 6'h02;
  localparam logic [CMD_W-1:0] CMD_RD   = 6'h04;
  localparam logic [CMD_W-1:0] CMD_STO  = 6'h08;
  localparam logic [CMD_W-1:0] CMD_ACK  = 6'h10;
  localparam logic [CMD_W-1:0] CMD_NACK = 6'h20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } ctrl_state_t;

  typedef enum logic {
    OP_WR = 1'b0,
    OP_RD = 1'b1
  } op_t;

  localparam int STEP_W = 3;

  localparam logic [STEP_W-1:0] STEP_DEV     = 3'd0;
  localparam logic [STEP_W-1:0] STEP_ADDR_HI = 3'd1;
  localparam logic [STEP_W-1:0] STEP_ADDR_LO = 3'd2;
  localparam logic [STEP_W-1:0] STEP_WR_DATA = 3'd3;
  localparam logic [STEP_W-1:0] STEP_RD_DEV  = 3'd3;
  localparam logic [STEP_W-1:0] STEP_RD_BYTE = 3'd4;

  function automatic logic [STEP_W-1:0] last_step(input op_t op);
    return (op == OP_WR) ? STEP_WR_DATA : STEP_RD_BYTE;
  endfunction

endpackage

// File: rtl/i2c_reg_ctrl.sv
// Register-transaction sequencer: expands one register write/read request into
// the ordered byte operations driven into the I2C/SCCB bit-shift engine.
module i2c_reg_ctrl
  import i2c_cmd_pkg::*;
#(
  parameter int ADDR_BYTES = 2
) (
  input  logic        Clk,
  input  logic        Rst_p,
  input  logic        wr_req,
  input  logic        rd_req,
  input  logic [6:0]  dev_addr,
  input  logic [15:0] reg_addr,
  input  logic [7:0]  wr_data,
  output logic [7:0]  rd_data,
  output logic        rw_done,
  output logic        busy,
  output logic        ack_err,
  output logic [5:0]  Cmd,
  output logic        Go,
  output logic [7:0]  Tx_DATA,
  input  logic        Trans_Done,
  input  logic        ack_o,
  input  logic [7:0]  Rx_DATA
);

  ctrl_state_t       state_reg, state_next;
  op_t               op_reg;
  logic [STEP_W-1:0] step_reg;
  logic [STEP_W-1:0] step_next;
  logic [6:0]        dev_addr_reg;
  logic [15:0]       reg_addr_reg;
  logic [7:0]        wr_data_reg;
  logic [7:0]        rd_data_reg;
  logic              ack_err_reg;
  logic              rw_done_reg;
  logic              at_last_step;
  logic              req_accept;
  logic [CMD_W-1:0]  tbl_cmd;
  logic [7:0]        tbl_tx;

  assign req_accept   = (state_reg == ST_IDLE) && (wr_req || rd_req);
  assign at_last_step = (step_reg == last_step(op_reg));

  // With a single-byte register address the high-address step is skipped
  always_comb begin
    step_next = step_reg + 3'd1;
    if ((ADDR_BYTES == 1) && (step_reg == STEP_DEV)) begin
      step_next = STEP_ADDR_LO;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst_p) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (wr_req || rd_req) state_next = ST_ISSUE;
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT:  if (Trans_Done) state_next = at_last_step ? ST_DONE : ST_ISSUE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst_p) begin
      op_reg       <= OP_WR;
      step_reg     <= STEP_DEV;
      dev_addr_reg <= '0;
      reg_addr_reg <= '0;
      wr_data_reg  <= '0;
      rd_data_reg  <= '0;
      ack_err_reg  <= 1'b0;
      rw_done_reg  <= 1'b0;
    end else begin
      // rw_done trails DONE by a cycle so it lands 2 cycles after the last Trans_Done
      rw_done_reg <= (state_reg == ST_DONE);
      if (req_accept) begin
        op_reg       <= wr_req ? OP_WR : OP_RD;
        step_reg     <= STEP_DEV;
        dev_addr_reg <= dev_addr;
        reg_addr_reg <= reg_addr;
        wr_data_reg  <= wr_data;
        ack_err_reg  <= 1'b0;
      end else if ((state_reg == ST_WAIT) && Trans_Done) begin
        if ((op_reg == OP_RD) && (step_reg == STEP_RD_BYTE)) begin
          rd_data_reg <= Rx_DATA;
        end else begin
          ack_err_reg <= ack_err_reg | ack_o;
        end
        if (!at_last_step) begin
          step_reg <= step_next;
        end
      end
    end
  end

  // Read is SCCB two-phase: address write closed by STO, then a fresh START for the data byte
  always_comb begin
    tbl_cmd = '0;
    tbl_tx  = '0;
    case ({op_reg, step_reg})
      {OP_WR, STEP_DEV}: begin
        tbl_cmd = CMD_STA | CMD_WR;
        tbl_tx  = {dev_addr_reg, 1'b0};
      end
      {OP_WR, STEP_ADDR_HI}: begin
        tbl_cmd = CMD_WR;
        tbl_tx  = reg_addr_reg[15:8];
      end
      {OP_WR, STEP_ADDR_LO}: begin
        tbl_cmd = CMD_WR;
        tbl_tx  = reg_addr_reg[7:0];
      end
      {OP_WR, STEP_WR_DATA}: begin
        tbl_cmd = CMD_WR | CMD_STO;
        tbl_tx  = wr_data_reg;
      end
      {OP_RD, STEP_DEV}: begin
        tbl_cmd = CMD_STA | CMD_WR;
        tbl_tx  = {dev_addr_reg, 1'b0};
      end
      {OP_RD, STEP_ADDR_HI}: begin
        tbl_cmd = CMD_WR;
        tbl_tx  = reg_addr_reg[15:8];
      end
      {OP_RD, STEP_ADDR_LO}: begin
        tbl_cmd = CMD_WR | CMD_STO;
        tbl_tx  = reg_addr_reg[7:0];
      end
      {OP_RD, STEP_RD_DEV}: begin
        tbl_cmd = CMD_STA | CMD_WR;
        tbl_tx  = {dev_addr_reg, 1'b1};
      end
      {OP_RD, STEP_RD_BYTE}: begin
        tbl_cmd = CMD_RD | CMD_NACK | CMD_STO;
        tbl_tx  = 8'h00;
      end
      default: begin
        tbl_cmd = '0;
        tbl_tx  = '0;
      end
    endcase
  end

  // Cmd/Tx_DATA stay stable through WAIT since the engine samples Cmd for the whole byte
  always_comb begin
    Go      = 1'b0;
    busy    = 1'b0;
    Cmd     = '0;
    Tx_DATA = '0;
    if ((state_reg == ST_ISSUE) || (state_reg == ST_WAIT)) begin
      busy    = 1'b1;
      Cmd     = tbl_cmd;
      Tx_DATA = tbl_tx;
      Go      = (state_reg == ST_ISSUE);
    end
  end

  assign rd_data = rd_data_reg;
  assign ack_err = ack_err_reg;
  assign rw_done = rw_done_reg;

endmodule
